// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM-to-downstream word loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    PUSH = 2'd2,
    DONE = 2'd3
  } loader_state_t;

  localparam logic [63:0] WORD_BYTES = 64'd4;

endpackage

// File: rtl/rom_loader.sv
// Copies words from a combinational ROM to a valid/ready write port,
// stopping at a terminator word or after MAX_WORDS accepted writes.
module rom_loader
  import loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 255,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_en_i,
  output logic [63:0] data_addr_o,
  input  logic [31:0] data_i,
  output logic        finish_o,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [63:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        busy_o,
  output logic [8:0]  word_cnt_o
);

  localparam logic [8:0] MAX_CNT  = 9'(MAX_WORDS);
  localparam bit         MAX_ZERO = (MAX_WORDS == 0);

  loader_state_t state;
  logic          we_prev;
  logic          armed;
  logic          start_edge;
  logic [8:0]    cnt_next;

  // armed stays low for the first clock after reset so a level already
  // high at release is absorbed into we_prev instead of starting a load.
  assign start_edge = armed & write_en_i & ~we_prev;
  assign cnt_next   = word_cnt_o + 9'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      data_addr_o <= BASE_ADDR;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_valid_o  <= 1'b0;
      finish_o    <= 1'b0;
      busy_o      <= 1'b0;
      word_cnt_o  <= '0;
      we_prev     <= 1'b0;
      armed       <= 1'b0;
    end else begin
      we_prev <= write_en_i;
      armed   <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state       <= READ;
            data_addr_o <= BASE_ADDR;
            word_cnt_o  <= '0;
            finish_o    <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        READ: begin
          if (MAX_ZERO || data_i == END_WORD) begin
            state    <= DONE;
            finish_o <= 1'b1;
            busy_o   <= 1'b0;
          end else begin
            wr_data_o  <= data_i;
            wr_addr_o  <= data_addr_o;
            wr_valid_o <= 1'b1;
            state      <= PUSH;
          end
        end
        PUSH: begin
          if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
            word_cnt_o <= cnt_next;
            if (cnt_next == MAX_CNT) begin
              state    <= DONE;
              finish_o <= 1'b1;
              busy_o   <= 1'b0;
            end else begin
              data_addr_o <= data_addr_o + WORD_BYTES;
              state       <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: three parameterisations against a queue-based
// reference of which ROM words should reach the write port.
module tb_rom_loader;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;
  localparam logic [63:0] BASE_C = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: default parameters
  logic        we_a, rdy_a, fin_a, vld_a, busy_a;
  logic [63:0] daddr_a, waddr_a;
  logic [31:0] din_a, wdata_a;
  logic [8:0]  cnt_a;
  logic [31:0] rom_a [64];
  assign din_a = rom_a[daddr_a[7:2]];

  rom_loader u_a (
    .clk_i(clk), .rst_i(rst), .write_en_i(we_a), .data_addr_o(daddr_a),
    .data_i(din_a), .finish_o(fin_a), .wr_valid_o(vld_a), .wr_ready_i(rdy_a),
    .wr_addr_o(waddr_a), .wr_data_o(wdata_a), .busy_o(busy_a), .word_cnt_o(cnt_a)
  );

  // ---------------- instance B: MAX_WORDS = 2
  logic        we_b, fin_b, vld_b, busy_b;
  logic        rdy_bc = 1'b1;
  logic [63:0] daddr_b, waddr_b;
  logic [31:0] din_b, wdata_b;
  logic [8:0]  cnt_b;
  logic [31:0] rom_b [64];
  assign din_b = rom_b[daddr_b[7:2]];

  rom_loader #(.MAX_WORDS(2)) u_b (
    .clk_i(clk), .rst_i(rst), .write_en_i(we_b), .data_addr_o(daddr_b),
    .data_i(din_b), .finish_o(fin_b), .wr_valid_o(vld_b), .wr_ready_i(rdy_bc),
    .wr_addr_o(waddr_b), .wr_data_o(wdata_b), .busy_o(busy_b), .word_cnt_o(cnt_b)
  );

  // ---------------- instance C: wrapping base, MAX_WORDS = 2
  logic        we_c, fin_c, vld_c, busy_c;
  logic [63:0] daddr_c, waddr_c;
  logic [31:0] din_c, wdata_c;
  logic [8:0]  cnt_c;
  logic [31:0] rom_c [64];
  assign din_c = rom_c[daddr_c[7:2]];

  rom_loader #(.BASE_ADDR(BASE_C), .MAX_WORDS(2)) u_c (
    .clk_i(clk), .rst_i(rst), .write_en_i(we_c), .data_addr_o(daddr_c),
    .data_i(din_c), .finish_o(fin_c), .wr_valid_o(vld_c), .wr_ready_i(rdy_bc),
    .wr_addr_o(waddr_c), .wr_data_o(wdata_c), .busy_o(busy_c), .word_cnt_o(cnt_c)
  );

  // Ready for A: 0 = always high, 1 = random, 2 = follows man_rdy.
  int   rdy_mode = 0;
  logic man_rdy  = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_a = 1'b1;
      1:       rdy_a = ($urandom_range(0, 3) != 0);
      default: rdy_a = man_rdy;
    endcase
  end

  // Monitors: record accepted writes; held write must not move while stalled.
  logic [63:0] obs_addr_a[$], obs_addr_b[$], obs_addr_c[$];
  logic [31:0] obs_data_a[$], obs_data_b[$], obs_data_c[$];
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        stall_pend = 1'b0;
  logic [63:0] held_addr;
  logic [31:0] held_data;
  logic [63:0] max_daddr_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_vld", 64'(vld_a), 64'd1);
        check("stall_addr", waddr_a, held_addr);
        check("stall_data", 64'(wdata_a), 64'(held_data));
      end
      if (vld_a && rdy_a) begin
        obs_addr_a.push_back(waddr_a);
        obs_data_a.push_back(wdata_a);
      end
      stall_pend = vld_a && !rdy_a;
      held_addr  = waddr_a;
      held_data  = wdata_a;
      if (vld_b) begin
        obs_addr_b.push_back(waddr_b);
        obs_data_b.push_back(wdata_b);
      end
      if (busy_b && daddr_b > max_daddr_b) max_daddr_b = daddr_b;
      if (vld_c) begin
        obs_addr_c.push_back(waddr_c);
        obs_data_c.push_back(wdata_c);
      end
    end
  end

  // Reference: walk the ROM from base, stop at the terminator or max words.
  function automatic void build_exp(input logic [63:0] base, input int maxw);
    logic [63:0] a;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < maxw; i++) begin
      a = base + 64'(4 * i);
      w = rom_a[a[7:2]];
      if (w == END_W) break;
      exp_addr.push_back(a);
      exp_data.push_back(w);
    end
  endfunction

  task automatic start_a();
    obs_addr_a.delete();
    obs_data_a.delete();
    we_a = 1'b1;
    @(posedge clk); #1;
    we_a = 1'b0;
  endtask

  task automatic wait_vld_a(input string tag);
    int c = 0;
    while (!vld_a && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(vld_a), 64'd1);
  endtask

  task automatic finish_a(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!fin_a && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_fin"}, 64'(fin_a), 64'd1);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_vld"}, 64'(vld_a), 64'd0);
    build_exp(64'h0, 255);
    check({tag, "_nwr"}, 64'(obs_addr_a.size()), 64'(exp_addr.size()));
    check({tag, "_cnt"}, 64'(cnt_a), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr_a.size(); i++) begin
      check({tag, "_addr"}, obs_addr_a[i], exp_addr[i]);
      check({tag, "_data"}, 64'(obs_data_a[i]), 64'(exp_data[i]));
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_rom_a(input int term_idx);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == END_W) w = 32'h0;
      rom_a[i] = w;
    end
    if (term_idx >= 0) rom_a[term_idx] = END_W;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int c;
    logic [31:0] w;
    rst = 1'b1;
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    fill_rom_a(3);
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == END_W) w = 32'h1;
      rom_b[i] = w;
      w = $urandom;
      if (w == END_W) w = 32'h2;
      rom_c[i] = w;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_daddr", daddr_a, 64'h0);
    check("rst_waddr", waddr_a, 64'h0);
    check("rst_wdata", 64'(wdata_a), 64'h0);
    check("rst_vld", 64'(vld_a), 64'h0);
    check("rst_fin", 64'(fin_a), 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);
    check("rst_cnt", 64'(cnt_a), 64'h0);
    check("rst_daddr_c", daddr_c, BASE_C);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // MAX_WORDS = 2, no terminator in ROM
    we_b = 1'b1;
    @(posedge clk); #1;
    we_b = 1'b0;
    c = 0;
    while (!fin_b && c < 100) begin @(negedge clk); c++; end
    check("b_fin", 64'(fin_b), 64'd1);
    check("b_nwr", 64'(obs_addr_b.size()), 64'd2);
    check("b_cnt", 64'(cnt_b), 64'd2);
    check("b_addr_max_lt8", 64'(max_daddr_b < 64'd8), 64'd1);
    for (int i = 0; i < 2 && i < obs_addr_b.size(); i++) begin
      check("b_addr", obs_addr_b[i], 64'(4 * i));
      check("b_data", 64'(obs_data_b[i]), 64'(rom_b[i]));
    end

    // Base address wrapping through zero
    @(posedge clk); #1;
    we_c = 1'b1;
    @(posedge clk); #1;
    we_c = 1'b0;
    c = 0;
    while (!fin_c && c < 100) begin @(negedge clk); c++; end
    check("c_fin", 64'(fin_c), 64'd1);
    check("c_nwr", 64'(obs_addr_c.size()), 64'd2);
    if (obs_addr_c.size() == 2) begin
      check("c_addr0", obs_addr_c[0], BASE_C);
      check("c_data0", 64'(obs_data_c[0]), 64'(rom_c[63]));
      check("c_addr1", obs_addr_c[1], 64'h0);
      check("c_data1", 64'(obs_data_c[1]), 64'(rom_c[0]));
    end
    @(posedge clk); #1;

    // Three words then terminator, ready held high
    rdy_mode = 0;
    @(posedge clk); #1;
    start_a();
    finish_a("three", 200, cyc);
    check("three_throughput", 64'(cyc <= 8), 64'd1);

    // Five-cycle stall during the first push
    rdy_mode = 2;
    man_rdy  = 1'b0;
    @(posedge clk); #1;
    start_a();
    wait_vld_a("stall_wait");
    for (int i = 0; i < 5; i++) begin
      check("stall_cnt", 64'(cnt_a), 64'd0);
      check("stall_addr0", waddr_a, 64'h0);
      check("stall_data0", 64'(wdata_a), 64'(rom_a[0]));
      @(negedge clk);
    end
    man_rdy = 1'b1;
    finish_a("stall", 300, cyc);

    // Second edge while pushing is ignored; edge after finish restarts
    man_rdy = 1'b0;
    @(posedge clk); #1;
    start_a();
    wait_vld_a("dup_wait");
    @(posedge clk); #1;
    we_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    we_a = 1'b0;
    man_rdy = 1'b1;
    finish_a("dup", 300, cyc);
    check("pre_restart_daddr", daddr_a, 64'd12);
    rdy_mode = 0;
    start_a();
    check("restart_fin", 64'(fin_a), 64'd0);
    check("restart_busy", 64'(busy_a), 64'd1);
    check("restart_daddr", daddr_a, 64'h0);
    finish_a("restart", 200, cyc);

    // Reset in the middle of a stalled push
    rdy_mode = 2;
    man_rdy  = 1'b0;
    @(posedge clk); #1;
    start_a();
    wait_vld_a("mrst_wait");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mrst_vld", 64'(vld_a), 64'd0);
    check("mrst_waddr", waddr_a, 64'h0);
    check("mrst_wdata", 64'(wdata_a), 64'h0);
    check("mrst_busy", 64'(busy_a), 64'd0);
    check("mrst_fin", 64'(fin_a), 64'd0);
    check("mrst_cnt", 64'(cnt_a), 64'd0);
    check("mrst_daddr", daddr_a, 64'h0);
    we_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    obs_addr_a.delete();
    obs_data_a.delete();
    repeat (4) begin @(posedge clk); #1; end
    check("held_we_busy", 64'(busy_a), 64'd0);
    check("held_we_vld", 64'(vld_a), 64'd0);
    check("held_we_nwr", 64'(obs_addr_a.size()), 64'd0);
    we_a = 1'b0;
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    start_a();
    finish_a("post_rst", 200, cyc);

    // Randomised ROM contents and ready pattern
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) begin
      fill_rom_a((k == 0) ? 0 : int'($urandom_range(1, 10)));
      @(posedge clk); #1;
      start_a();
      finish_a("rand", 500, cyc);
    end

    // No terminator: stops at MAX_WORDS
    rdy_mode = 0;
    fill_rom_a(-1);
    @(posedge clk); #1;
    start_a();
    finish_a("maxw", 2000, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
